pipeline_consumer: RTL and testbench

PIPELINE_CONSUMER -- requirements
Module: pipeline_consumer

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/consumer_lane.sv | 90 +++++++++
 rtl/pipeline_consumer.sv | 61 ++++++
 tb/tb_pipeline_consumer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared lane state, pattern constants and expected-value helpers
package pipeline_pkg;

  localparam int IDX_W = 3;
  localparam int DRAIN_W = 4;
  localparam logic [31:0] PATTERN_SEED = 32'h10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FLUSH = 2'd2
  } lane_state_t;

  function automatic logic [31:0] expected_lane1(input logic [IDX_W-1:0] idx);
    return PATTERN_SEED << idx;
  endfunction

  function automatic logic [31:0] expected_lane2(input logic [IDX_W-1:0] idx);
    return PATTERN_SEED >> idx;
  endfunction

  // dir 0 walks the seed upward (lane 1), dir 1 walks it downward (lane 2)
  function automatic logic [31:0] expected_value(input logic dir, input logic [IDX_W-1:0] idx);
    return dir ? expected_lane2(idx) : expected_lane1(idx);
  endfunction

endpackage

// File: rtl/consumer_lane.sv
// rtl/consumer_lane.sv - one lane tracker: IDLE/TRACK/FLUSH FSM, index, drain and error counters
module consumer_lane
  import pipeline_pkg::*;
#(
  parameter int ERR_W        = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter bit LANE_DIR     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       beat,
  input  logic              valid,
  output logic              flush,
  output logic [ERR_W-1:0]  err_count,
  output logic              tracking,
  output logic [IDX_W-1:0]  idx,
  output logic              err_event
);

  lane_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      flush_q <= (state_d == ST_FLUSH);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    err_d     = err_q;
    err_event = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid && beat == expected_value(LANE_DIR, '0)) begin
          state_d = ST_TRACK;
          idx_d   = IDX_W'(1);
        end
      end
      ST_TRACK: begin
        if (valid) begin
          if (beat == expected_value(LANE_DIR, idx_q)) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            state_d   = ST_FLUSH;
            drain_d   = '0;
            err_event = 1'b1;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        // Last drain cycle returns to IDLE so FLUSH lasts exactly FLUSH_CYCLES
        if (drain_q == DRAIN_W'(FLUSH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        drain_d = '0;
      end
    endcase
  end

  assign flush     = flush_q;
  assign err_count = err_q;
  assign tracking  = (state_q == ST_TRACK);
  assign idx       = idx_q;

endmodule

// File: rtl/pipeline_consumer.sv
// rtl/pipeline_consumer.sv - two-lane pattern consumer with sticky alarm; PIPELINE_CONSUMER_CROSSCHECK_EN adds lane index cross-check
module pipeline_consumer
  import pipeline_pkg::*;
#(
  parameter int ERR_W        = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pipeline1_outputs,
  input  logic [31:0]       pipeline2_outputs,
  input  logic [1:0]        out_valid,
  output logic              flush_1,
  output logic              flush_2,
  output logic [ERR_W-1:0]  err_count_1,
  output logic [ERR_W-1:0]  err_count_2,
  output logic [1:0]        locked,
  output logic              alarm
);

  logic [IDX_W-1:0] idx_1, idx_2;
  logic             err_event_1, err_event_2;
  logic             cross_hit;
  logic             alarm_q;

  consumer_lane #(
    .ERR_W(ERR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .LANE_DIR(1'b0)
  ) u_lane1 (
    .clk(clk), .reset(reset), .beat(pipeline1_outputs), .valid(out_valid[0]),
    .flush(flush_1), .err_count(err_count_1), .tracking(locked[0]),
    .idx(idx_1), .err_event(err_event_1)
  );

  consumer_lane #(
    .ERR_W(ERR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .LANE_DIR(1'b1)
  ) u_lane2 (
    .clk(clk), .reset(reset), .beat(pipeline2_outputs), .valid(out_valid[1]),
    .flush(flush_2), .err_count(err_count_2), .tracking(locked[1]),
    .idx(idx_2), .err_event(err_event_2)
  );

`ifdef PIPELINE_CONSUMER_CROSSCHECK_EN
  // Both lanes see the same upstream cadence, so their indices must agree
  assign cross_hit = (&locked) && (&out_valid) && (idx_1 != idx_2);
`else
  logic unused_idx;
  assign unused_idx = ^{idx_1, idx_2};
  assign cross_hit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (err_event_1 || err_event_2 || cross_hit) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: tb/tb_pipeline_consumer.sv
// tb/tb_pipeline_consumer.sv - scoreboard bench for pipeline_consumer against a cycle model
module tb_pipeline_consumer;

  localparam int ERR_W = 8;
  localparam int FLUSH_CYCLES = 2;
  localparam int ERR_MAX = 255;
  localparam int M_IDLE = 0, M_TRACK = 1, M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pipeline1_outputs = '0;
  logic [31:0] pipeline2_outputs = '0;
  logic [1:0]  out_valid = '0;
  logic        flush_1, flush_2, alarm;
  logic [ERR_W-1:0] err_count_1, err_count_2;
  logic [1:0]  locked;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] locked;
    logic       f1;
    logic       f2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       alarm;
  } exp_t;

  exp_t sb[$];

  int m_st[2];
  int m_idx[2];
  int m_dr[2];
  int m_err[2];
  bit m_alarm;

  always #5 clk = ~clk;

  pipeline_consumer #(.ERR_W(ERR_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .pipeline1_outputs(pipeline1_outputs), .pipeline2_outputs(pipeline2_outputs),
    .out_valid(out_valid), .flush_1(flush_1), .flush_2(flush_2),
    .err_count_1(err_count_1), .err_count_2(err_count_2),
    .locked(locked), .alarm(alarm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_expect(input int lane, input int idx);
    logic [31:0] seed;
    seed = 32'h10000;
    if (lane == 0) return seed << idx;
    return seed >> idx;
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] v, input logic [31:0] b1, input logic [31:0] b2);
    logic [31:0] b[2];
    b[0] = b1;
    b[1] = b2;
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_st[l] = M_IDLE; m_idx[l] = 0; m_dr[l] = 0; m_err[l] = 0;
      end
      m_alarm = 0;
      return;
    end
`ifdef PIPELINE_CONSUMER_CROSSCHECK_EN
    if (m_st[0] == M_TRACK && m_st[1] == M_TRACK && v == 2'b11 && m_idx[0] != m_idx[1])
      m_alarm = 1;
`endif
    for (int l = 0; l < 2; l++) begin
      if (m_st[l] == M_IDLE) begin
        if (v[l] && b[l] == 32'h10000) begin
          m_st[l] = M_TRACK; m_idx[l] = 1;
        end
      end else if (m_st[l] == M_TRACK) begin
        if (v[l]) begin
          if (b[l] == model_expect(l, m_idx[l])) begin
            m_idx[l] = (m_idx[l] + 1) % 8;
          end else begin
            m_st[l] = M_FLUSH; m_dr[l] = 0; m_alarm = 1;
            if (m_err[l] < ERR_MAX) m_err[l]++;
          end
        end
      end else begin
        m_dr[l]++;
        if (m_dr[l] == FLUSH_CYCLES) begin
          m_st[l] = M_IDLE; m_idx[l] = 0; m_dr[l] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input logic [1:0] v, input logic [31:0] b1, input logic [31:0] b2);
    exp_t e;
    exp_t o;
    reset = rst;
    out_valid = v;
    pipeline1_outputs = b1;
    pipeline2_outputs = b2;
    model_step(rst, v, b1, b2);
    e.locked = {m_st[1] == M_TRACK, m_st[0] == M_TRACK};
    e.f1 = (m_st[0] == M_FLUSH);
    e.f2 = (m_st[1] == M_FLUSH);
    e.e1 = 8'(m_err[0]);
    e.e2 = 8'(m_err[1]);
    e.alarm = m_alarm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      o = sb.pop_front();
      check("sb_locked", locked, o.locked);
      check("sb_flush_1", flush_1, o.f1);
      check("sb_flush_2", flush_2, o.f2);
      check("sb_err_1", err_count_1, o.e1);
      check("sb_err_2", err_count_2, o.e2);
      check("sb_alarm", alarm, o.alarm);
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 2'b00, '0, '0);
    cyc(1'b1, 2'b00, '0, '0);
  endtask

  initial begin
    logic [1:0]  rv;
    logic [31:0] rb1, rb2;

    do_reset();
    check("rst_locked", locked, 2'b00);
    check("rst_alarm", alarm, 0);
    check("rst_err_1", err_count_1, 0);
    check("rst_flush_2", flush_2, 0);

    // lane 1 walks the full upward pattern and wraps
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 2'b01, 32'h10000 << (i % 8), '0);
      if (i == 0) check("l1_lock_first", locked[0], 1);
    end
    check("l1_wrap_locked", locked[0], 1);
    check("l1_wrap_err", err_count_1, 0);
    check("l1_wrap_flush", flush_1, 0);

    // lane 1 in IDLE ignores a wrong beat, then locks on the seed
    do_reset();
    cyc(1'b0, 2'b01, 32'h40000, '0);
    check("idle_wrong_locked", locked[0], 0);
    check("idle_wrong_err", err_count_1, 0);
    check("idle_wrong_alarm", alarm, 0);
    cyc(1'b0, 2'b01, 32'h10000, '0);
    check("idle_seed_locked", locked[0], 1);

    // lane 2 mismatch at idx 3
    do_reset();
    cyc(1'b0, 2'b10, '0, 32'h10000);
    cyc(1'b0, 2'b10, '0, 32'h8000);
    cyc(1'b0, 2'b10, '0, 32'h4000);
    cyc(1'b0, 2'b10, '0, 32'h1234);
    check("l2_mm_flush_a", flush_2, 1);
    check("l2_mm_err", err_count_2, 1);
    check("l2_mm_alarm", alarm, 1);
    check("l2_mm_locked", locked[1], 0);
    cyc(1'b0, 2'b10, '0, 32'h10000);
    check("l2_mm_flush_b", flush_2, 1);
    cyc(1'b0, 2'b00, '0, '0);
    check("l2_mm_flush_end", flush_2, 0);
    check("l2_mm_idle", locked[1], 0);

    // lane 1 at idx 2, lane 2 at idx 5, both valid and matching
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 2'b10, '0, 32'h10000 >> i);
    for (int i = 0; i < 2; i++) cyc(1'b0, 2'b01, 32'h10000 << i, '0);
    cyc(1'b0, 2'b11, 32'h40000, 32'h800);
`ifdef PIPELINE_CONSUMER_CROSSCHECK_EN
    check("xchk_alarm", alarm, 1);
`else
    check("xchk_alarm", alarm, 0);
`endif
    check("xchk_flush", {flush_2, flush_1}, 2'b00);
    check("xchk_err", {err_count_2, err_count_1}, 16'h0000);
    check("xchk_locked", locked, 2'b11);

    // simultaneous mismatch, then reset during the first FLUSH cycle
    do_reset();
    cyc(1'b0, 2'b11, 32'h10000, 32'h10000);
    cyc(1'b0, 2'b11, 32'h0, 32'h0);
    check("dual_flush", {flush_2, flush_1}, 2'b11);
    check("dual_err", {err_count_2, err_count_1}, 16'h0101);
    cyc(1'b1, 2'b11, 32'h10000, 32'h10000);
    check("dual_rst_flush", {flush_2, flush_1}, 2'b00);
    check("dual_rst_err", {err_count_2, err_count_1}, 16'h0000);
    check("dual_rst_locked", locked, 2'b00);
    check("dual_rst_alarm", alarm, 0);

    // error counter saturation; valid seed beats during FLUSH must be ignored
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 2'b01, 32'h10000, '0);
      cyc(1'b0, 2'b01, 32'hdead, '0);
      cyc(1'b0, 2'b01, 32'h10000, '0);
      cyc(1'b0, 2'b00, '0, '0);
    end
    check("sat_err_1", err_count_1, 255);
    check("sat_err_2", err_count_2, 0);

    // randomised mix of matching and corrupt beats with occasional reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = 2'($urandom_range(0, 3));
      rb1 = ($urandom_range(0, 4) != 0) ?
            ((m_st[0] == M_TRACK) ? model_expect(0, m_idx[0]) : 32'h10000) : $urandom;
      rb2 = ($urandom_range(0, 4) != 0) ?
            ((m_st[1] == M_TRACK) ? model_expect(1, m_idx[1]) : 32'h10000) : $urandom;
      cyc(($urandom_range(0, 63) == 0), rv, rb1, rb2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
